// File: rtl/score_ram_sched.sv
// Scores_RAM sequencer: writes the gap-penalty boundary row on start, then
// arbitrates the RAM write port (compute engine) and read port (reader).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, gap          latch gap and run the init pass (ignored during init)
//   busy, init_done     init pass in progress / one-cycle completion pulse
//   wr_req/addr/data    write request, accepted when wr_req && wr_ready
//   rd_req/addr         read request, accepted when rd_req && rd_ready
//   rd_valid, rd_data   read result, three cycles after acceptance
//   addr_err            sticky out-of-range flag, cleared by rst or start
//   ram_*               Scores_RAM control, address and data pins
module score_ram_sched #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8:0]       gap,
    output logic             busy,
    output logic             init_done,
    input  logic             wr_req,
    input  logic [BitAddr:0] wr_addr,
    input  logic [8:0]       wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    input  logic [BitAddr:0] rd_addr,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [8:0]       rd_data,
    output logic             addr_err,
    output logic [8:0]       ram_din,
    output logic             ram_en_din,
    output logic             ram_we,
    output logic [BitAddr:0] ram_addr_din,
    output logic             ram_en_dout,
    output logic [BitAddr:0] ram_addr_dout,
    input  logic [8:0]       ram_dout
);

    localparam int AW = BitAddr + 1;
    localparam logic [AW-1:0] NMAX = AW'(N);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q;
    logic [8:0]    acc_q;
    logic [8:0]    gap_q;
    logic          init_done_q;
    logic          addr_err_q;
    logic          wr_v_q;
    logic [AW-1:0] wr_addr_q;
    logic [8:0]    wr_data_q;
    logic          rd_en_q;
    logic [AW-1:0] rd_addr_q;
    logic          p1_v_q, p2_v_q, p2_ok_q;
    logic          rd_valid_q;
    logic [8:0]    rd_data_q;

    logic in_init, in_run, go;
    logic wr_acc, rd_acc, wr_oor, rd_oor;

    assign in_init = (state_q == INIT);
    assign in_run  = (state_q == RUN);
    // start is only honoured outside the init pass
    assign go      = start && !in_init;
    assign wr_oor  = (wr_addr > NMAX);
    assign rd_oor  = (rd_addr > NMAX);
    assign wr_acc  = wr_req && wr_ready;
    assign rd_acc  = rd_req && rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    if (i_q == NMAX) state_d = RUN;
            RUN:     if (start) state_d = INIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q         <= '0;
            acc_q       <= '0;
            gap_q       <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            wr_v_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            p1_v_q      <= 1'b0;
            p2_v_q      <= 1'b0;
            p2_ok_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (go) begin
                gap_q <= gap;
                i_q   <= '0;
                acc_q <= '0;
            end else if (in_init) begin
                i_q   <= i_q + AW'(1);
                acc_q <= acc_q + gap_q;
            end
            init_done_q <= in_init && (i_q == NMAX);

            if (go) begin
                addr_err_q <= 1'b0;
            end else if ((wr_acc && wr_oor) || (rd_acc && rd_oor)) begin
                addr_err_q <= 1'b1;
            end

            // out-of-range requests are accepted but never reach the RAM
            wr_v_q <= wr_acc && !wr_oor;
            if (wr_acc && !wr_oor) begin
                wr_addr_q <= wr_addr;
                wr_data_q <= wr_data;
            end

            rd_en_q <= rd_acc && !rd_oor;
            if (rd_acc && !rd_oor) begin
                rd_addr_q <= rd_addr;
            end
            p1_v_q     <= rd_acc;
            p2_v_q     <= p1_v_q;
            p2_ok_q    <= rd_en_q;
            rd_valid_q <= p2_v_q;
            if (p2_v_q) begin
                rd_data_q <= p2_ok_q ? ram_dout : 9'h000;
            end
        end
    end

    always_comb begin
        busy      = in_init;
        init_done = init_done_q;
        wr_ready  = in_run;
        // hold a read off while a same-address write is being requested
        rd_ready  = in_run && !(wr_req && (wr_addr == rd_addr));
        rd_valid  = rd_valid_q;
        rd_data   = rd_data_q;
        addr_err  = addr_err_q;
        // the init pass owns the write port while it runs
        ram_en_din    = in_init || wr_v_q;
        ram_we        = in_init || wr_v_q;
        ram_addr_din  = in_init ? i_q : wr_addr_q;
        ram_din       = in_init ? acc_q : wr_data_q;
        ram_en_dout   = rd_en_q;
        ram_addr_dout = rd_addr_q;
    end

endmodule

// File: tb/tb_score_ram_sched.sv
// Directed bench for score_ram_sched with a behavioural Scores_RAM (N=4).
module tb_score_ram_sched;

    localparam int N  = 4;
    localparam int BA = $clog2(N + 1);
    localparam int AW = BA + 1;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [8:0]    gap;
    logic          busy, init_done;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready, rd_valid;
    logic [8:0]    rd_data;
    logic          addr_err;
    logic [8:0]    ram_din;
    logic          ram_en_din, ram_we;
    logic [AW-1:0] ram_addr_din;
    logic          ram_en_dout;
    logic [AW-1:0] ram_addr_dout;
    logic [8:0]    ram_dout;

    logic [8:0] mem [16];
    logic [8:0] init_exp [5];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    score_ram_sched #(.N(N), .BitAddr(BA)) dut (
        .clk(clk), .rst(rst), .start(start), .gap(gap),
        .busy(busy), .init_done(init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .addr_err(addr_err),
        .ram_din(ram_din), .ram_en_din(ram_en_din), .ram_we(ram_we),
        .ram_addr_din(ram_addr_din), .ram_en_dout(ram_en_dout),
        .ram_addr_dout(ram_addr_dout), .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_en_dout) ram_dout <= mem[ram_addr_dout];
        if (ram_en_din && ram_we) mem[ram_addr_din] <= ram_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc();
            #1;
            if (init_done) seen = 1'b1;
        end
        chk("init_done_seen", 32'(seen), 1);
    endtask

    initial begin
        init_exp = '{9'h000, 9'h1FE, 9'h1FC, 9'h1FA, 9'h1F8};
        for (int k = 0; k < 16; k++) mem[k] = 9'h000;
        ram_dout = 9'h000;
        rst = 1'b1; start = 1'b0; gap = 9'h000;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        cyc(); cyc(); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_en_din", 32'(ram_en_din), 0);
        chk("rst_en_dout", 32'(ram_en_dout), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_addr_err", 32'(addr_err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_addr_din", 32'(ram_addr_din), 0);
        chk("idle_wr_ready", 32'(wr_ready), 0);

        // init pass, gap = -2; a start mid-pass must be ignored
        cyc(); rst = 1'b0; start = 1'b1; gap = 9'h1FE; #1;
        chk("idle_busy", 32'(busy), 0);
        for (int k = 0; k <= N; k++) begin
            cyc();
            start = (k == 1); gap = (k == 1) ? 9'h003 : 9'h1FE;
            rd_req = 1'b1; wr_req = 1'b1; #1;
            chk("init_busy", 32'(busy), 1);
            chk("init_we", 32'(ram_we && ram_en_din), 1);
            chk("init_addr", 32'(ram_addr_din), k);
            chk("init_din", 32'(ram_din), 32'(init_exp[k]));
            chk("init_ready", 32'(wr_ready || rd_ready), 0);
            chk("init_done_early", 32'(init_done), 0);
        end
        cyc(); start = 1'b0; rd_req = 1'b0; wr_req = 1'b0; #1;
        chk("init_done_pulse", 32'(init_done), 1);
        chk("run_busy", 32'(busy), 0);
        chk("run_we_idle", 32'(ram_we), 0);
        chk("run_wr_ready", 32'(wr_ready), 1);
        cyc(); #1;
        chk("init_done_single", 32'(init_done), 0);

        // write addr2 then read addr2 on the next cycle
        cyc(); wr_req = 1'b1; wr_addr = 2; wr_data = 9'h005; #1;
        cyc(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 2; #1;
        chk("w2_we", 32'(ram_we), 1);
        chk("w2_addr", 32'(ram_addr_din), 2);
        chk("w2_din", 32'(ram_din), 9'h005);
        chk("r2_ready", 32'(rd_ready), 1);
        cyc(); rd_req = 1'b0; #1;
        chk("r2_en_dout", 32'(ram_en_dout), 1);
        chk("r2_addr_dout", 32'(ram_addr_dout), 2);
        chk("w2_we_off", 32'(ram_we), 0);
        cyc(); #1;
        chk("r2_valid_early", 32'(rd_valid), 0);
        cyc(); #1;
        chk("r2_valid", 32'(rd_valid), 1);
        chk("r2_data", 32'(rd_data), 9'h005);
        cyc(); #1;
        chk("r2_valid_off", 32'(rd_valid), 0);

        // RAW hazard on addr3
        cyc(); wr_req = 1'b1; wr_addr = 3; wr_data = 9'h011;
        rd_req = 1'b1; rd_addr = 3; #1;
        chk("raw_rd_ready", 32'(rd_ready), 0);
        chk("raw_wr_ready", 32'(wr_ready), 1);
        cyc(); wr_req = 1'b0; #1;
        chk("raw_rd_ready2", 32'(rd_ready), 1);
        chk("raw_we", 32'(ram_we), 1);
        chk("raw_no_rd", 32'(ram_en_dout), 0);
        cyc(); rd_req = 1'b0; #1;
        chk("raw_en_dout", 32'(ram_en_dout), 1);
        cyc(); #1;
        cyc(); #1;
        chk("raw_valid", 32'(rd_valid), 1);
        chk("raw_data", 32'(rd_data), 9'h011);

        // simultaneous write addr1 / read addr0
        cyc(); wr_req = 1'b1; wr_addr = 1; wr_data = 9'h0AA;
        rd_req = 1'b1; rd_addr = 0; #1;
        chk("sim_rd_ready", 32'(rd_ready), 1);
        cyc(); wr_req = 1'b0; rd_req = 1'b0; #1;
        chk("sim_both", 32'({ram_we, ram_en_dout}), 3);
        cyc(); #1;
        cyc(); #1;
        chk("sim_data", 32'({rd_valid, rd_data}), 32'h200);

        // out-of-range write and read
        cyc(); wr_req = 1'b1; wr_addr = 5; wr_data = 9'h077; #1;
        cyc(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 6; #1;
        chk("oor_no_we", 32'(ram_we), 0);
        chk("oor_err", 32'(addr_err), 1);
        cyc(); rd_req = 1'b0; #1;
        chk("oor_no_rd", 32'(ram_en_dout), 0);
        cyc(); #1;
        cyc(); #1;
        chk("oor_rd_valid", 32'(rd_valid), 1);
        chk("oor_rd_data", 32'(rd_data), 0);
        chk("oor_err_sticky", 32'(addr_err), 1);
        chk("oor_mem4", 32'(mem[4]), 9'h1F8);

        // re-init with gap = +1; start clears addr_err
        cyc(); start = 1'b1; gap = 9'h001; #1;
        cyc(); start = 1'b0; #1;
        chk("start_clr_err", 32'(addr_err), 0);
        chk("reinit_busy", 32'(busy), 1);
        wait_init_done();
        cyc(); rd_req = 1'b1; rd_addr = 0; #1;
        cyc(); rd_addr = 1; #1;
        cyc(); rd_addr = 2; #1;
        cyc(); rd_req = 1'b0; #1;
        chk("b2b_v0", 32'({rd_valid, rd_data}), 32'h200);
        cyc(); #1;
        chk("b2b_v1", 32'({rd_valid, rd_data}), 32'h201);
        cyc(); #1;
        chk("b2b_v2", 32'({rd_valid, rd_data}), 32'h202);
        cyc(); #1;
        chk("b2b_end", 32'(rd_valid), 0);

        // reset mid-read drops the pending result
        cyc(); rd_req = 1'b1; rd_addr = 1; #1;
        cyc(); rd_req = 1'b0; rst = 1'b1; #1;
        cyc(); rst = 1'b0; #1;
        chk("rrst_en_dout", 32'(ram_en_dout), 0);
        chk("rrst_valid", 32'(rd_valid), 0);
        cyc(); #1;
        chk("rrst_valid2", 32'(rd_valid), 0);

        // reset on the third init cycle, then restart
        cyc(); start = 1'b1; gap = 9'h1FE; #1;
        cyc(); start = 1'b0; #1;
        cyc(); #1;
        cyc(); rst = 1'b1; #1;
        chk("irst_addr", 32'(ram_addr_din), 2);
        cyc(); rst = 1'b0; start = 1'b1; #1;
        chk("irst_strobes", 32'({ram_we, ram_en_din, ram_en_dout}), 0);
        chk("irst_idle", 32'({busy, wr_ready}), 0);
        cyc(); start = 1'b0; #1;
        chk("restart_a0", 32'({ram_we, ram_addr_din}), 32'h10);
        chk("restart_d0", 32'(ram_din), 0);
        cyc(); #1;
        chk("restart_a1", 32'(ram_addr_din), 1);
        chk("restart_d1", 32'(ram_din), 9'h1FE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_ram_sched.md
Name: score_ram_sched

Overview:
- Sequencer and arbiter for the Scores_RAM row buffer in the Needleman-Wunsch datapath.
- On start it runs an initialisation pass that writes the gap-penalty boundary row, address i = i*gap for i = 0..N.
- It then shares the RAM's write port with the cell-compute engine and its read port with the diagonal/traceback reader.
- It owns every RAM control strobe and enforces the read-after-write ordering on a shared address.

Parameters:
- N, 128, sequence length; the RAM holds addresses 0..N.
- BitAddr, $clog2(N+1), address ports are [BitAddr:0].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse: latch gap, begin init pass.
- gap  in  9  signed two's-complement gap penalty.
- busy  out  1  high in INIT.
- init_done  out  1  one-cycle pulse after last init write is issued.
- wr_req  in  1  compute-engine write request.
- wr_addr  in  BitAddr+1  write address.
- wr_data  in  9  score to write.
- wr_ready  out  1  write accepted when wr_req&&wr_ready.
- rd_req  in  1  read request.
- rd_addr  in  BitAddr+1  read address.
- rd_ready  out  1  read accepted when rd_req&&rd_ready.
- rd_valid  out  1  read data valid.
- rd_data  out  9  read score.
- addr_err  out  1  sticky; set on any accepted request with address > N.
- ram_din  out  9  to Scores_RAM din.
- ram_en_din  out  1  to en_din.
- ram_we  out  1  to we.
- ram_addr_din  out  BitAddr+1  to addr_din.
- ram_en_dout  out  1  to en_dout.
- ram_addr_dout  out  BitAddr+1  to addr_dout.
- ram_dout  in  9  from Scores_RAM dout; registered, 1-cycle read latency.

Behaviour:
- Reset: state IDLE; busy, init_done, rd_valid, addr_err, ram_en_din, ram_we and ram_en_dout are 0; ram_din, both RAM addresses and rd_data are 0. Reset asserted mid-INIT or mid-read aborts the operation: no further strobes, and in-flight rd_valid is dropped.
- States: IDLE, INIT, RUN.
  - IDLE: start -> INIT.
  - INIT: after address N is written -> RUN.
  - RUN: start -> INIT (re-init); otherwise stays in RUN.
  - start while in INIT is ignored.
- INIT:
  - Counter i runs 0..N, one write per cycle.
  - Drives ram_en_din = ram_we = 1, ram_addr_din = i, ram_din = acc.
  - acc starts at 0 and adds the latched gap each cycle; 9-bit result, wraps modulo 512, no saturation.
  - Duration is N+1 cycles. init_done pulses in the cycle after the write of address N.
  - wr_ready = rd_ready = 0 throughout INIT and in IDLE.
- RUN, write path:
  - wr_ready = 1.
  - A write accepted in cycle t drives ram_en_din = ram_we = 1, ram_addr_din = wr_addr, ram_din = wr_data in cycle t+1. Strobes are registered.
- RUN, read path:
  - rd_ready = 1, except 0 when wr_req is high and wr_addr == rd_addr in the same cycle (RAW hazard). The read is then accepted the next cycle and returns the new data.
  - A read accepted at t drives ram_en_dout = 1, ram_addr_dout = rd_addr at t+1.
  - ram_dout is valid at t+2. rd_valid = 1 and rd_data = ram_dout are registered at t+3.
  - Back-to-back reads are accepted every cycle, fully pipelined.
- A simultaneous write and read to different addresses are both accepted in the same cycle.
- Address > N: the request is still accepted; no RAM strobe is issued, addr_err is set, and for a read rd_valid still pulses with rd_data = 0. addr_err is cleared only by rst or start.
- When nothing is accepted, all RAM strobes are 0 in the following cycle.

Test Plan:
- N=4, gap=-2 (9'h1FE), start -> 5 consecutive writes: addr0..4 = 9'h000, 1FE, 1FC, 1FA, 1F8; init_done pulses 1 cycle after addr4; ready signals stay 0 during INIT.
- RUN: write addr2=9'h005 at t, read addr2 at t+1 -> ram_we at t+1; rd_valid with rd_data = 9'h005 at t+4.
- Same-cycle wr_req and rd_req, both addr3, data 9'h011 -> rd_ready=0 that cycle; read accepted next cycle; rd_data = 9'h011.
- Reads of addr 0,1,2 on consecutive cycles after init with gap=+1 -> rd_valid held 3 cycles with data 0, 1, 2.
- Write to addr 5 (N=4) -> no ram_we; addr_err=1 and stays 1; a subsequent start clears it.
- rst asserted on the 3rd INIT cycle -> next cycle all strobes are 0 and state is IDLE; a new start restarts from addr 0.
